// File: rtl/vec_cache_diag_wr_sched.sv
// Per-channel write-injection scheduler: round-robin grant among west/north/south writers, then
// locks the east lane until the winner's cmd and full data burst have been forwarded.
module vec_cache_diag_wr_sched #(
   parameter int unsigned CMD_W  = 64,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned BEAT_W = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2:0]             req_vld,
   output logic [2:0]             req_rdy,
   input  logic [2:0][CMD_W-1:0]  req_cmd,
   input  logic [2:0][BEAT_W-1:0] req_beats,
   input  logic [2:0]             dat_vld,
   output logic [2:0]             dat_rdy,
   input  logic [2:0][DATA_W-1:0] dat_pld,
   input  logic                   rd_busy,
   output logic                   out_cmd_vld,
   output logic [CMD_W-1:0]       out_cmd_pld,
   output logic                   out_dat_vld,
   output logic [DATA_W-1:0]      out_dat_pld,
   output logic [1:0]             out_dir,
   output logic                   busy
);

   typedef enum logic {StIdle, StData} state_e;

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [2:0]        owner_q, owner_d;
   logic              cmd_vld_q, cmd_vld_d;
   logic [CMD_W-1:0]  cmd_pld_q, cmd_pld_d;
   logic              dat_vld_q, dat_vld_d;
   logic [DATA_W-1:0] dat_pld_q, dat_pld_d;
   logic [1:0]        dir_q, dir_d;

   logic [1:0]        win_idx;
   logic [1:0]        rr_idx;
   logic [2:0]        win_oh;
   logic              grant;
   logic              beat_acc;
   logic [DATA_W-1:0] sel_dat;

   function automatic logic [1:0] dir_code(input logic [1:0] src);
      logic [1:0] code;
      unique case (src)
         2'd0:    code = 2'b00;
         2'd1:    code = 2'b11;
         2'd2:    code = 2'b10;
         default: code = 2'b00;
      endcase
      return code;
   endfunction

   // Scan from the lowest priority upward so the source at ptr_q wins last (highest priority).
   always_comb begin
      win_idx = '0;
      rr_idx  = '0;
      for (int k = 2; k >= 0; k--) begin
         rr_idx = 2'((32'(ptr_q) + 32'(k)) % 32'd3);
         if (req_vld[rr_idx]) begin
            win_idx = rr_idx;
         end
      end
      win_oh = 3'b001 << win_idx;
   end

   // Reset gates the grant so nothing is handshaken while the block is held in reset.
   assign grant   = (state_q == StIdle) && !rd_busy && (|req_vld) && rst_n;
   assign req_rdy = grant ? win_oh : 3'b000;
   assign dat_rdy = (state_q == StData) ? owner_q : 3'b000;
   assign beat_acc = (state_q == StData) && (|(dat_vld & owner_q));

   always_comb begin
      sel_dat = '0;
      for (int i = 0; i < 3; i++) begin
         if (owner_q[i]) begin
            sel_dat = dat_pld[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      cmd_vld_d = 1'b0;
      cmd_pld_d = cmd_pld_q;
      dat_vld_d = 1'b0;
      dat_pld_d = dat_pld_q;
      dir_d     = dir_q;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               state_d   = StData;
               ptr_d     = (win_idx == 2'd2) ? 2'd0 : 2'(win_idx + 2'd1);
               cnt_d     = req_beats[win_idx];
               owner_d   = win_oh;
               cmd_vld_d = 1'b1;
               cmd_pld_d = req_cmd[win_idx];
               dir_d     = dir_code(win_idx);
            end
         end
         StData: begin
            if (beat_acc) begin
               dat_vld_d = 1'b1;
               dat_pld_d = sel_dat;
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         cnt_q     <= '0;
         owner_q   <= '0;
         cmd_vld_q <= 1'b0;
         cmd_pld_q <= '0;
         dat_vld_q <= 1'b0;
         dat_pld_q <= '0;
         dir_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         cmd_vld_q <= cmd_vld_d;
         cmd_pld_q <= cmd_pld_d;
         dat_vld_q <= dat_vld_d;
         dat_pld_q <= dat_pld_d;
         dir_q     <= dir_d;
      end
   end

   assign out_cmd_vld = cmd_vld_q;
   assign out_cmd_pld = cmd_pld_q;
   assign out_dat_vld = dat_vld_q;
   assign out_dat_pld = dat_pld_q;
   assign out_dir     = dir_q;
   assign busy        = (state_q == StData);

   a_req_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_rdy));
   a_dat_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dat_rdy));
   a_no_cmd_dat_overlap: assert property (@(posedge clk) disable iff (!rst_n)
      !(out_cmd_vld && out_dat_vld));

endmodule
